// File: rtl/program_loader.sv
// Instruction-memory loader: packs field/branch beats into 9-bit words, buffers them in a
// small FIFO and writes them to consecutive addresses, tracking program length and overflow.
module program_loader #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_kind,
  input  logic [2:0] in_opcode,
  input  logic [2:0] in_a,
  input  logic [2:0] in_b,
  input  logic [5:0] in_off6,
  input  logic       in_last,
  output logic       imem_we,
  output logic [6:0] imem_addr,
  output logic [8:0] imem_wdata,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic [7:0] prog_len
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t          state_r;
  logic [8:0]      fifo_mem_r [DEPTH];
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic [6:0]      acc_cnt_r;
  logic            acc_full_r;

  logic [8:0]      beat_word_s;
  logic            accept_s;
  logic            push_s;
  logic            pop_s;
  logic            ovf_s;

  // Beat encoding, handshake and FIFO push/pop decisions.
  always_comb begin
    beat_word_s = {in_opcode, in_a, in_b};
    if (in_kind) begin
      beat_word_s = {3'b010, in_off6};
    end else begin
      beat_word_s = {in_opcode, in_a, in_b};
    end
    in_ready = (state_r == S_LOAD) && (count_r != CW'(DEPTH));
    accept_s = in_valid && in_ready;
    // Once 128 beats are in, any further accepted beat is the overflow beat and is dropped.
    ovf_s    = accept_s && acc_full_r;
    push_s   = accept_s && !acc_full_r;
    pop_s    = (count_r != {CW{1'b0}}) && (state_r != S_ERROR);
  end

  // FIFO storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= beat_word_s;
    end
  end

  // Control FSM, FIFO pointers, accept counter and registered memory-write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      acc_cnt_r  <= 7'd0;
      acc_full_r <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= 7'd0;
      imem_wdata <= 9'd0;
      prog_len   <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r  <= wr_ptr_r + AW'(1);
        acc_cnt_r <= acc_cnt_r + 7'd1;
        if (acc_cnt_r == 7'd127) begin
          acc_full_r <= 1'b1;
        end
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase

      // The write address is the number of words already written.
      imem_we <= pop_s;
      if (pop_s) begin
        imem_addr  <= prog_len[6:0];
        imem_wdata <= fifo_mem_r[rd_ptr_r];
        prog_len   <= prog_len + 8'd1;
      end

      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r    <= S_LOAD;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            acc_cnt_r  <= 7'd0;
            acc_full_r <= 1'b0;
            prog_len   <= 8'd0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ovf_s) begin
            state_r  <= S_ERROR;
            count_r  <= {CW{1'b0}};
            busy     <= 1'b0;
            overflow <= 1'b1;
          end else if (push_s && in_last) begin
            state_r <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (count_r == {CW{1'b0}}) begin
            state_r <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        S_ERROR: begin
          state_r <= S_ERROR;
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
